// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register with an optional skid entry,
// synchronous flush to a bubble value and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int unsigned             DATA_W    = 64,
  parameter logic [DATA_W-1:0]       FLUSH_VAL = {DATA_W{1'b0}},
  parameter int unsigned             SKID      = 1,
  parameter int unsigned             CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_stats,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit HAS_SKID = (SKID != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              m_valid_reg;
  logic [DATA_W-1:0] m_data_reg;
  logic              s_valid_reg;
  logic [DATA_W-1:0] s_data_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic              push;
  logic              pop;
  logic              m_drains;

  generate
    if (HAS_SKID) begin : g_skid
      // Ready depends only on the skid register, so no comb path from out_ready.
      assign in_ready = !s_valid_reg && !flush && !rst;
    end else begin : g_noskid
      assign in_ready = (!m_valid_reg || out_ready) && !flush && !rst;
    end
  endgenerate

  assign push     = in_valid && in_ready;
  assign pop      = m_valid_reg && out_ready;
  assign m_drains = !m_valid_reg || pop;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= FLUSH_VAL;
      s_valid_reg <= 1'b0;
      s_data_reg  <= FLUSH_VAL;
    end else if (m_drains) begin
      if (s_valid_reg) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= s_data_reg;
        s_valid_reg <= push;
        if (push) begin
          s_data_reg <= in_data;
        end
      end else if (push) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= in_data;
      end else begin
        m_valid_reg <= 1'b0;
        m_data_reg  <= FLUSH_VAL;
      end
    end else if (push && HAS_SKID) begin
      // M is held, so a push can only land in the (empty) skid entry.
      s_valid_reg <= 1'b1;
      s_data_reg  <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      stall_cnt_reg <= '0;
    end else if (m_valid_reg && !out_ready && !flush && stall_cnt_reg != CNT_MAX) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign out_valid = m_valid_reg;
  assign out_data  = m_data_reg;
  assign occupancy = {1'b0, m_valid_reg} + {1'b0, s_valid_reg};
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a SKID=1 stage, a SKID=0 stage and a
// SKID=1 stage with a 4-bit stall counter.
module tb_pipe_stage_skid;

  localparam logic [7:0] FV = 8'hF0;

  logic       clk = 1'b0;
  logic       rst, flush, clr_stats, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [1:0] occupancy;
  logic [15:0] stall_cnt;

  logic       v0, r0, in_ready0, out_valid0;
  logic [7:0] d0, out_data0;
  logic [1:0] occupancy0;
  logic [15:0] stall_cnt0;

  logic       in_ready4, out_valid4;
  logic [7:0] out_data4;
  logic [1:0] occupancy4;
  logic [3:0] stall_cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(8), .FLUSH_VAL(FV), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_skid #(.DATA_W(8), .FLUSH_VAL(FV), .SKID(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .flush(1'b0), .clr_stats(1'b0),
    .in_valid(v0), .in_ready(in_ready0), .in_data(d0),
    .out_valid(out_valid0), .out_ready(r0), .out_data(out_data0),
    .occupancy(occupancy0), .stall_cnt(stall_cnt0));

  pipe_stage_skid #(.DATA_W(8), .FLUSH_VAL(FV), .SKID(1), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .clr_stats(clr_stats),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; clr_stats = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    v0 = 1'b0; d0 = 8'h00; r0 = 1'b0;

    // Reset held two cycles with a valid beat offered upstream
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, FV);
    chk("rst_occ", occupancy, 0);
    tick();
    chk("rst2_in_ready", in_ready, 0);
    chk("rst2_occ", occupancy, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_stall", stall_cnt, 0);

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      tick();
      chk($sformatf("stream_data_%0d", i), out_data, i);
      chk($sformatf("stream_valid_%0d", i), out_valid, 1);
      chk($sformatf("stream_occ_%0d", i), occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drain_valid", out_valid, 0);
    chk("stream_drain_data", out_data, FV);
    chk("stream_stall", stall_cnt, 0);

    // Back-pressure: skid absorbs 0x11, 0x12 is held upstream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h10;
    tick();
    chk("bp_occ1", occupancy, 1);
    chk("bp_in_ready1", in_ready, 1);
    in_data = 8'h11;
    tick();
    chk("bp_occ2", occupancy, 2);
    chk("bp_head", out_data, 8'h10);
    in_data = 8'h12;
    #1;
    chk("bp_full_in_ready", in_ready, 0);
    tick();
    chk("bp_hold_head", out_data, 8'h10);
    chk("bp_hold_occ", occupancy, 2);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_lag", in_ready, 0);
    tick();
    chk("bp_out1", out_data, 8'h11);
    chk("bp_out1_occ", occupancy, 1);
    chk("bp_in_ready_free", in_ready, 1);
    tick();
    chk("bp_out2", out_data, 8'h12);
    chk("bp_out2_occ", occupancy, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_stall", stall_cnt, 2);

    // Flush at occupancy 2 with a beat offered
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h20;
    tick();
    in_data = 8'h21;
    tick();
    chk("fl_pre_occ", occupancy, 2);
    flush = 1'b1; in_data = 8'h99;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_data", out_data, FV);
    chk("fl_stall", stall_cnt, 3);
    tick();
    chk("fl_no99_valid", out_valid, 0);
    chk("fl_no99_data", out_data, FV);

    // SKID=0 stage: combinational ready, same-cycle pop and push
    r0 = 1'b0; v0 = 1'b1; d0 = 8'h31;
    tick();
    chk("s0_occ1", occupancy0, 1);
    d0 = 8'h32;
    #1;
    chk("s0_in_ready_full", in_ready0, 0);
    r0 = 1'b1;
    #1;
    chk("s0_in_ready_pop", in_ready0, 1);
    tick();
    chk("s0_occ_pushpop", occupancy0, 1);
    chk("s0_data", out_data0, 8'h32);
    v0 = 1'b0;
    tick();
    chk("s0_empty", out_valid0, 0);
    chk("s0_empty_data", out_data0, FV);

    // Counter saturation on the 4-bit stage
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h40; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0; in_valid = 1'b0;
    chk("sat_clr_start", stall_cnt4, 0);
    repeat (20) tick();
    chk("sat_cnt4", stall_cnt4, 15);
    chk("sat_cnt16", stall_cnt, 20);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("sat_clr4", stall_cnt4, 0);
    chk("sat_clr16", stall_cnt, 0);

    // Reset mid-operation drops the held beat
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_occ", occupancy, 0);
    chk("midrst_data", out_data, FV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
